booth_multiplier_seq: RTL
=========================

BOOTH_MULTIPLIER_SEQ -- requirements
Module: booth_multiplier_seq

Interface
REQ-001 The block SHALL have exactly one clock, `clock` (input, 1 bit), and all state SHALL update on its rising edge.
REQ-002 Reset SHALL be asynchronous and active-low, on `clear` (input, 1 bit).
REQ-003 `start` SHALL be an input, 1 bit: a one-cycle request to begin a multiply.
REQ-004 `mcand` SHALL be an input, 32 bits: the multiplicand, two's complement.
REQ-005 `mplier` SHALL be an input, 32 bits: the multiplier, two's complement.
REQ-006 `signed_op` SHALL be an input, 1 bit: 1 selects signed, 0 selects unsigned; the port SHALL exist only when MUL_UNSIGNED_EN is defined.
REQ-007 `busy` SHALL be an output, 1 bit, high while iterating.
REQ-008 `done` SHALL be an output, 1 bit: a one-cycle pulse when the product is valid.
REQ-009 `hi` SHALL be an output, 32 bits: product bits [63:32], destined for the HI register.
REQ-010 `lo` SHALL be an output, 32 bits: product bits [31:0], destined for the LO register.

Function
REQ-011 The block SHALL implement a radix-4 (bit-pair) Booth multiplier with states IDLE, RUN and DONE.
REQ-012 In IDLE, or in DONE, with `start`=1 at a rising edge, the block SHALL:
- latch `mcand` into M, sign-extended to 34 bits;
- latch `mplier` into Q with an appended Q[-1]=0;
- clear the 34-bit accumulator A and the iteration count;
- enter RUN.
REQ-013 Each RUN cycle SHALL:
- recode {Q[1],Q[0],Q[-1]} as 000/111=0, 001/010=+M, 011=+2M, 100=-2M, 101/110=-M;
- add the recoded value to A (34-bit wrap-around);
- arithmetic-shift {A,Q,Q[-1]} right by 2;
- increment the count.
REQ-014 RUN SHALL last exactly 16 cycles for a signed multiply; the block SHALL then enter DONE.
REQ-015 In DONE the block SHALL:
- assert `done` for exactly one cycle;
- drive {hi,lo} = {A[31:0],Q[31:0]}, the exact 64-bit product;
- return to IDLE unless `start` is asserted in that same cycle.
REQ-016 Latency: with `start` sampled at edge k, `done` SHALL be high in the cycle following edge k+17.
REQ-017 `busy` SHALL be 1 exactly while the state is RUN.
REQ-018 `start` asserted in RUN SHALL be ignored, with no effect on the operation in progress.
REQ-019 `start` in DONE SHALL be accepted: the result is still presented with `done`=1 that cycle, and a new operation begins.
REQ-020 `hi` and `lo` SHALL hold their last product through IDLE until the next DONE.
REQ-021 Operand inputs SHALL be sampled only at the accepting edge; later changes SHALL NOT affect the result.
REQ-022 Boundary operands SHALL produce exact results with no overflow flag: 0x80000000, 0x7FFFFFFF, 0 and -1 in any combination.

Reset
REQ-023 Assertion of `clear` SHALL immediately force:
- state=IDLE, `busy`=0, `done`=0;
- `hi`=0, `lo`=0;
- A, Q, M and the count to 0.
REQ-024 Reset during RUN SHALL abandon the operation without ever raising `done`; the first `start` after deassertion SHALL behave normally.

Configuration
REQ-025 The configuration macro SHALL be MUL_UNSIGNED_EN.
REQ-026 With MUL_UNSIGNED_EN defined and `signed_op`=0, the block SHALL:
- zero-extend `mcand` and `mplier` to 34 bits;
- run 17 RUN cycles, giving a latency of 18;
- produce the exact unsigned 64-bit product.
REQ-027 With MUL_UNSIGNED_EN defined and `signed_op`=1, behaviour SHALL be identical to the signed-only build.
REQ-028 Without MUL_UNSIGNED_EN, the `signed_op` port and the 17th-iteration logic SHALL be absent, and every operation SHALL be signed with 16 iterations.

Structure
REQ-029 A shared package mul_pkg SHALL hold:
- the state enumeration;
- constants MUL_WIDTH=32, ACC_WIDTH=34, ITER_SIGNED=16, ITER_UNSIGNED=17;
- the Booth select encoding (ZERO, PM, P2M, NM, N2M).
REQ-030 The recoder SHALL be the single combinational sub-module booth_recoder: it takes the 3 bits and M, and returns the 34-bit addend.
REQ-031 The 34-bit add SHALL be implemented within the block using the codebase's carry-lookahead adder style.

Verification
REQ-032 The bench SHALL cover the following directed scenarios:
- 3 x 5: `done` at cycle k+17 -> hi=0x00000000, lo=0x0000000F; `busy` high for exactly 16 cycles.
- 0xFFFFFFFF x 0xFFFFFFFF signed -> hi=0x00000000, lo=0x00000001; 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0x00000000.
- 0x7FFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFF, lo=0x80000001; `start` pulsed again mid-RUN with other operands -> same result, no extra `done`.
- `clear` asserted at RUN cycle 8 -> `busy`, `done`, `hi` and `lo` go to 0 immediately; a following 2 x 7 -> lo=0x0000000E.
- Back-to-back: `start` in the DONE cycle -> first product presented, second `done` 17 cycles later.
- MUL_UNSIGNED_EN, `signed_op`=0: 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, `done` at k+18.

Source files
------------

// File: rtl/mul_pkg.sv
// mul_pkg: shared definitions for the sequential radix-4 Booth multiplier.
//   - FSM state enumeration
//   - operand/accumulator widths and iteration counts
//   - Booth select encoding and the bit-triple decoder
// Imported by booth_recoder and booth_multiplier_seq.
package mul_pkg;

   localparam int unsigned MUL_WIDTH     = 32;
   localparam int unsigned ACC_WIDTH     = 34;
   localparam int unsigned ITER_SIGNED   = 16;
   localparam int unsigned ITER_UNSIGNED = 17;
   localparam int unsigned CNT_WIDTH     = 5;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } mul_state_e;

   typedef enum logic [2:0] {
      ZERO,
      PM,
      P2M,
      NM,
      N2M
   } booth_sel_e;

   // {Q[1], Q[0], Q[-1]} -> partial-product select
   function automatic booth_sel_e booth_select(input logic [2:0] bits);
      booth_sel_e sel;
      sel = ZERO;
      unique case (bits)
         3'b000, 3'b111: sel = ZERO;
         3'b001, 3'b010: sel = PM;
         3'b011:         sel = P2M;
         3'b100:         sel = N2M;
         3'b101, 3'b110: sel = NM;
         default:        sel = ZERO;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/booth_recoder.sv
// booth_recoder: combinational radix-4 Booth recoder.
// Ports:
//   bits_i   - {Q[1], Q[0], Q[-1]} of the current multiplier window
//   m_i      - multiplicand, already extended to ACC_WIDTH
//   addend_o - 0, +M, +2M, -M or -2M, ACC_WIDTH bits (wrap-around)
module booth_recoder
   import mul_pkg::*;
(
   input  logic [2:0]           bits_i,
   input  logic [ACC_WIDTH-1:0] m_i,
   output logic [ACC_WIDTH-1:0] addend_o
);

   booth_sel_e           sel;
   logic [ACC_WIDTH-1:0] m2;

   assign sel = booth_select(bits_i);
   // M carries two guard bits, so dropping its top bit for 2M loses nothing
   assign m2  = {m_i[ACC_WIDTH-2:0], 1'b0};

   always_comb begin
      addend_o = '0;
      unique case (sel)
         ZERO:    addend_o = '0;
         PM:      addend_o = m_i;
         P2M:     addend_o = m2;
         NM:      addend_o = ~m_i + 1'b1;
         N2M:     addend_o = ~m2 + 1'b1;
         default: addend_o = '0;
      endcase
   end

endmodule

// File: rtl/booth_multiplier_seq.sv
// booth_multiplier_seq: sequential radix-4 Booth multiplier, 32x32 -> 64.
// Ports:
//   clock     - rising-edge clock
//   clear     - asynchronous active-low reset
//   start     - one-cycle request, accepted in IDLE or DONE
//   mcand     - multiplicand (32 bits)
//   mplier    - multiplier (32 bits)
//   signed_op - 1 = signed, 0 = unsigned (only with MUL_UNSIGNED_EN)
//   busy      - high while iterating (RUN)
//   done      - one-cycle pulse when {hi, lo} holds a new product
//   hi, lo    - product bits [63:32] and [31:0]; held until the next result
// Build option: define MUL_UNSIGNED_EN to add signed_op and the 17-iteration
// unsigned mode. Default build is signed-only, 16 iterations.
module booth_multiplier_seq
   import mul_pkg::*;
(
   input  logic                 clock,
   input  logic                 clear,
   input  logic                 start,
   input  logic [MUL_WIDTH-1:0] mcand,
   input  logic [MUL_WIDTH-1:0] mplier,
`ifdef MUL_UNSIGNED_EN
   input  logic                 signed_op,
`endif
   output logic                 busy,
   output logic                 done,
   output logic [MUL_WIDTH-1:0] hi,
   output logic [MUL_WIDTH-1:0] lo
);

`ifdef MUL_UNSIGNED_EN
   // Unsigned needs a 17th pair, so Q carries two zero-extension bits
   localparam int unsigned QW = ACC_WIDTH;
`else
   localparam int unsigned QW = MUL_WIDTH;
`endif
   localparam int unsigned NUM_GRP = (ACC_WIDTH - 1) / 4;

   mul_state_e           state_q, state_d;
   logic [CNT_WIDTH-1:0] count_q, count_d;
   logic [ACC_WIDTH-1:0] m_q, m_d, acc_q, acc_d;
   logic [QW-1:0]        q_q, q_d;
   logic                 qm1_q, qm1_d;
   logic                 done_q, done_d;
   logic [MUL_WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

   logic [ACC_WIDTH-1:0]   m_load, addend, sum;
   logic [QW-1:0]          q_load;
   logic                   last_iter;
   logic [2*MUL_WIDTH-1:0] product;

`ifdef MUL_UNSIGNED_EN
   logic uns_q, uns_d;

   assign m_load    = signed_op ? {{2{mcand[MUL_WIDTH-1]}}, mcand} : {2'b00, mcand};
   assign q_load    = signed_op ? {{2{mplier[MUL_WIDTH-1]}}, mplier} : {2'b00, mplier};
   assign last_iter = (count_q == (uns_q ? CNT_WIDTH'(ITER_UNSIGNED - 1)
                                         : CNT_WIDTH'(ITER_SIGNED - 1)));
   // Signed stops two bits short of the end of Q; unsigned shifts all the way
   assign product   = uns_q ? {acc_q[29:0], q_q} : {acc_q[MUL_WIDTH-1:0], q_q[QW-1:2]};
`else
   assign m_load    = {{2{mcand[MUL_WIDTH-1]}}, mcand};
   assign q_load    = mplier;
   assign last_iter = (count_q == CNT_WIDTH'(ITER_SIGNED - 1));
   assign product   = {acc_q[MUL_WIDTH-1:0], q_q};
`endif

   booth_recoder u_recoder (
      .bits_i   ({q_q[1], q_q[0], qm1_q}),
      .m_i      (m_q),
      .addend_o (addend)
   );

   // Carry-lookahead add: 4-bit groups with group generate/propagate, then
   // a short tail for the two guard bits. Carry-out is discarded (wrap).
   logic [ACC_WIDTH-2:0] cla_g;
   logic [ACC_WIDTH-1:0] cla_p, cla_c;
   logic                 grp_g, grp_p;

   always_comb begin
      cla_g = acc_q[ACC_WIDTH-2:0] & addend[ACC_WIDTH-2:0];
      cla_p = acc_q ^ addend;
      cla_c = '0;
      grp_g = 1'b0;
      grp_p = 1'b1;
      for (int k = 0; k < NUM_GRP; k++) begin
         grp_g = 1'b0;
         grp_p = 1'b1;
         for (int j = 0; j < 4; j++) begin
            grp_g = cla_g[4*k+j] | (cla_p[4*k+j] & grp_g);
            grp_p = grp_p & cla_p[4*k+j];
         end
         for (int j = 0; j < 3; j++) begin
            cla_c[4*k+j+1] = cla_g[4*k+j] | (cla_p[4*k+j] & cla_c[4*k+j]);
         end
         cla_c[4*k+4] = grp_g | (grp_p & cla_c[4*k]);
      end
      for (int i = 4 * NUM_GRP; i < ACC_WIDTH - 1; i++) begin
         cla_c[i+1] = cla_g[i] | (cla_p[i] & cla_c[i]);
      end
      sum = cla_p ^ cla_c;
   end

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      m_d     = m_q;
      acc_d   = acc_q;
      q_d     = q_q;
      qm1_d   = qm1_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
`ifdef MUL_UNSIGNED_EN
      uns_d   = uns_q;
`endif
      unique case (state_q)
         StIdle, StDone: begin
            if (state_q == StDone) begin
               {hi_d, lo_d} = product;
               done_d       = 1'b1;
               state_d      = StIdle;
            end
            if (start) begin
               m_d     = m_load;
               q_d     = q_load;
               qm1_d   = 1'b0;
               acc_d   = '0;
               count_d = '0;
               state_d = StRun;
`ifdef MUL_UNSIGNED_EN
               uns_d   = ~signed_op;
`endif
            end
         end
         StRun: begin
            // Arithmetic shift of {A, Q, Q[-1]} by two after the add
            acc_d   = {{2{sum[ACC_WIDTH-1]}}, sum[ACC_WIDTH-1:2]};
            q_d     = {sum[1:0], q_q[QW-1:2]};
            qm1_d   = q_q[1];
            count_d = count_q + 1'b1;
            if (last_iter) state_d = StDone;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state_q <= StIdle;
         count_q <= '0;
         m_q     <= '0;
         acc_q   <= '0;
         q_q     <= '0;
         qm1_q   <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
`ifdef MUL_UNSIGNED_EN
         uns_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         m_q     <= m_d;
         acc_q   <= acc_d;
         q_q     <= q_d;
         qm1_q   <= qm1_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
`ifdef MUL_UNSIGNED_EN
         uns_q   <= uns_d;
`endif
      end
   end

   assign busy = (state_q == StRun);
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule
